button_conditioner: RTL and testbench

- Front-end input conditioning stage. It sits between the raw board pushbuttons and slide switch and the `TimerWithClock` system inputs `buttons_export` and `switch_export`.
- Per input it provides a 2-FF synchronizer and a debounce filter.
- For each of the 4 keys it also runs a hold FSM that emits one-cycle press, release, long-press and auto-repeat event pulses. These drive the alarm-setting UX (fast increment while held).

---
 rtl/button_conditioner.sv | 156 +++++++++++++++
 tb/tb_button_conditioner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Purpose: 2-FF sync + debounce for 4 active-low keys and 1 switch, plus per-key press/release/long/repeat pulses.
// Latency: clean raw edge to debounced level = DEBOUNCE_CYCLES + 2 cycles; pulses coincide with the level change.
// Backpressure: none; inputs are sampled every cycle and event pulses are single-cycle, never held.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [3:0] key_n,
    input  logic       sw_raw,
    output logic [3:0] buttons_export,
    output logic       switch_export,
    output logic [3:0] press_pulse,
    output logic [3:0] release_pulse,
    output logic [3:0] long_press,
    output logic [3:0] repeat_pulse
);

    // Channel layout: bits [3:0] are the keys, bit 4 is the switch.
    localparam int NCH  = 5;
    localparam int NKEY = 4;
    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX);

    // Keys idle high (released), the switch idles low.
    localparam logic [NCH-1:0] RST_LVL = 5'b01111;

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] L_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] R_LAST = HW'(REPEAT_CYCLES - 1);

    localparam logic [1:0] S_RELEASED = 2'd0;
    localparam logic [1:0] S_PRESSED  = 2'd1;
    localparam logic [1:0] S_LONG     = 2'd2;

    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] lvl;
    logic [NCH-1:0] accept;
    logic [DW-1:0]  dcnt [NCH];

    logic [1:0]     state [NKEY];
    logic [HW-1:0]  hcnt  [NKEY];

    assign raw = {sw_raw, key_n};

    // Two-flop synchronizer for every asynchronous input bit.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sync1 <= RST_LVL;
            sync2 <= RST_LVL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A level change is accepted on the edge where the disagreeing run reaches its terminal count.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NCH; i++) begin
            accept[i] = (sync2[i] != lvl[i]) && (dcnt[i] == D_LAST);
        end
    end

    // Debounce filter: any agreeing sample clears the run counter, so short glitches never propagate.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            lvl <= RST_LVL;
            for (int i = 0; i < NCH; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] == lvl[i]) begin
                    dcnt[i] <= '0;
                end else if (accept[i]) begin
                    lvl[i]  <= sync2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + DW'(1);
                end
            end
        end
    end

    // Hold FSM per key; the event pulses are registered on the same edge that moves the debounced level.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            press_pulse   <= '0;
            release_pulse <= '0;
            long_press    <= '0;
            repeat_pulse  <= '0;
            for (int k = 0; k < NKEY; k++) begin
                state[k] <= S_RELEASED;
                hcnt[k]  <= '0;
            end
        end else begin
            press_pulse   <= '0;
            release_pulse <= '0;
            long_press    <= '0;
            repeat_pulse  <= '0;
            for (int k = 0; k < NKEY; k++) begin
                case (state[k])
                    S_RELEASED: begin
                        // lvl is 1 here, so an accept means a 1->0 press.
                        if (accept[k] && lvl[k]) begin
                            press_pulse[k] <= 1'b1;
                            state[k]       <= S_PRESSED;
                            hcnt[k]        <= '0;
                        end
                    end
                    S_PRESSED: begin
                        // Release takes priority over the long-press threshold.
                        if (accept[k] && !lvl[k]) begin
                            release_pulse[k] <= 1'b1;
                            state[k]         <= S_RELEASED;
                            hcnt[k]          <= '0;
                        end else if (hcnt[k] == L_LAST) begin
                            long_press[k] <= 1'b1;
                            state[k]      <= S_LONG;
                            hcnt[k]       <= '0;
                        end else begin
                            hcnt[k] <= hcnt[k] + HW'(1);
                        end
                    end
                    S_LONG: begin
                        // Release takes priority over the repeat threshold.
                        if (accept[k] && !lvl[k]) begin
                            release_pulse[k] <= 1'b1;
                            state[k]         <= S_RELEASED;
                            hcnt[k]          <= '0;
                        end else if (hcnt[k] == R_LAST) begin
                            repeat_pulse[k] <= 1'b1;
                            hcnt[k]         <= '0;
                        end else begin
                            hcnt[k] <= hcnt[k] + HW'(1);
                        end
                    end
                    default: begin
                        state[k] <= S_RELEASED;
                        hcnt[k]  <= '0;
                    end
                endcase
            end
        end
    end

    assign buttons_export = lvl[3:0];
    assign switch_export  = lvl[4];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short debounce/hold/repeat periods.
// Drives inputs on the falling edge and compares on the next falling edge.
// Mix of fixed vectors, hand sequences and random traffic against a reference model.
module tb_button_conditioner;

    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_n;
    logic       sw_raw;
    logic [3:0] buttons;
    logic       sw_out;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
    logic [3:0] rep;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .key_n         (key_n),
        .sw_raw        (sw_raw),
        .buttons_export(buttons),
        .switch_export (sw_out),
        .press_pulse   (press),
        .release_pulse (rel),
        .long_press    (lng),
        .repeat_pulse  (rep)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // Reference model: raw input reaches the filter two edges later; a level is adopted
    // after D consecutive disagreeing samples; hold events derive from the age of a press.
    logic [4:0] m_s1  = 5'b01111;
    logic [4:0] m_s2  = 5'b01111;
    logic [4:0] m_lvl = 5'b01111;
    int         m_run [5];
    bit         m_held[4];
    int         m_age [4];
    logic [3:0] e_press, e_rel, e_long, e_rep;

    task automatic model_edge(input logic r, input logic [4:0] raw);
        logic [4:0] old_lvl;
        logic [4:0] sample;
        e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
        if (!r) begin
            m_s1 = 5'b01111; m_s2 = 5'b01111; m_lvl = 5'b01111;
            for (int i = 0; i < 5; i++) m_run[i] = 0;
            for (int k = 0; k < 4; k++) begin m_held[k] = 0; m_age[k] = 0; end
        end else begin
            old_lvl = m_lvl;
            sample  = m_s2;
            for (int i = 0; i < 5; i++) begin
                if (sample[i] == m_lvl[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] == D) begin m_lvl[i] = sample[i]; m_run[i] = 0; end
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
            for (int k = 0; k < 4; k++) begin
                if (old_lvl[k] && !m_lvl[k]) begin
                    e_press[k] = 1'b1; m_held[k] = 1; m_age[k] = 0;
                end else if (!old_lvl[k] && m_lvl[k]) begin
                    if (m_held[k]) e_rel[k] = 1'b1;
                    m_held[k] = 0;
                end else if (m_held[k]) begin
                    m_age[k]++;
                    if (m_age[k] == L) e_long[k] = 1'b1;
                    else if (m_age[k] > L && ((m_age[k] - L) % R) == 0) e_rep[k] = 1'b1;
                end
            end
        end
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge, compare after.
    task automatic step(input logic r, input logic [3:0] k, input logic s);
        rst_n  = r;
        key_n  = k;
        sw_raw = s;
        @(posedge clk);
        model_edge(r, {s, k});
        @(negedge clk);
        cyc++;
        check("model", {buttons, sw_out, press, rel, lng, rep},
              {m_lvl[3:0], m_lvl[4], e_press, e_rel, e_long, e_rep});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 4'hF, 1'b0);
    endtask

    typedef struct {
        logic        rst_n;
        logic [3:0]  key_n;
        logic        sw;
        logic [3:0]  exp_buttons;
        logic        exp_sw;
        logic [15:0] exp_pulses; // {press, release, long, repeat}
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] k, input logic s,
                                input logic [3:0] eb, input logic es, input logic [15:0] ep);
        vec_t v;
        v.rst_n = r; v.key_n = k; v.sw = s;
        v.exp_buttons = eb; v.exp_sw = es; v.exp_pulses = ep;
        vecs.push_back(v);
    endfunction

    int         n_press, n_rel, press_at;
    logic [3:0] rk;
    logic       rs;
    logic       rr;

    initial begin
        rst_n = 1'b0; key_n = 4'hF; sw_raw = 1'b0;
        for (int i = 0; i < 5; i++) m_run[i] = 0;
        for (int k = 0; k < 4; k++) begin m_held[k] = 0; m_age[k] = 0; end

        // Reset with key0 held, fresh press after release, then release and a 3-cycle glitch on key2.
        for (int i = 0; i < 3; i++) add(1'b0, 4'hE, 1'b0, 4'hF, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) add(1'b1, 4'hE, 1'b0, 4'hF, 1'b0, 16'h0000);
        add(1'b1, 4'hE, 1'b0, 4'hE, 1'b0, 16'h1000);
        add(1'b1, 4'hE, 1'b0, 4'hE, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) add(1'b1, 4'hF, 1'b0, 4'hE, 1'b0, 16'h0000);
        add(1'b1, 4'hF, 1'b0, 4'hF, 1'b0, 16'h0100);
        add(1'b1, 4'hF, 1'b0, 4'hF, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) add(1'b1, 4'hB, 1'b0, 4'hF, 1'b0, 16'h0000);
        for (int i = 0; i < 8; i++) add(1'b1, 4'hF, 1'b0, 4'hF, 1'b0, 16'h0000);

        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].key_n, vecs[i].sw);
            check("vector", {buttons, sw_out, press, rel, lng, rep},
                  {vecs[i].exp_buttons, vecs[i].exp_sw, vecs[i].exp_pulses});
        end

        // Clean press held 40 cycles: press, long, three repeats, then release beats a repeat threshold.
        for (int n = 1; n <= 50; n++) begin
            step(1'b1, (n <= 40) ? 4'hE : 4'hF, 1'b0);
            check("press_hold", {buttons[0], press[0], lng[0], rep[0], rel[0]},
                  {!(n >= 6 && n < 46), n == 6, n == 26, (n == 31 || n == 36 || n == 41), n == 46});
        end
        idle(5);

        // Bouncing key1: toggles every 2 cycles for 20 cycles, then settles low.
        n_press = 0; n_rel = 0; press_at = 0;
        for (int n = 1; n <= 32; n++) begin
            step(1'b1, (n <= 20 && (((n - 1) / 2) % 2) == 1) ? 4'hF : 4'hD, 1'b0);
            if (press[1]) begin n_press++; press_at = n; end
            if (rel[1]) n_rel++;
        end
        check("bounce_press_count", n_press, 1);
        check("bounce_press_time", press_at, 26);
        check("bounce_release_count", n_rel, 0);
        idle(10);

        // Debounced release lands exactly when the long-press threshold would fire.
        for (int n = 1; n <= 35; n++) begin
            step(1'b1, (n <= 20) ? 4'hE : 4'hF, 1'b0);
            check("release_wins", {press[0], lng[0], rel[0]}, {n == 6, 1'b0, n == 26});
        end
        idle(5);

        // Keys 0 and 3 together, switch rising in the same cycle.
        for (int n = 1; n <= 8; n++) begin
            step(1'b1, 4'h6, 1'b1);
            check("simultaneous", {press, sw_out}, {(n == 6) ? 4'h9 : 4'h0, n >= 6});
        end
        for (int i = 0; i < 10; i++) step(1'b1, 4'hF, 1'b1);
        idle(10);

        // Random traffic with sticky levels and occasional resets, checked by the model.
        rk = 4'hF; rs = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 29) == 0) rk[b] = ~rk[b];
            if ($urandom_range(0, 29) == 0) rs = ~rs;
            rr = ($urandom_range(0, 499) != 0);
            step(rr, rk, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
